// File: rtl/pcie_wr_req_queue.sv
// pcie_wr_req_queue
//   Round-robin collector of 128-bit HySim write packets from NSRC core sources.
//   Each accepted packet has bit 127 cleared and the source-ID field overwritten
//   with the granted source index. It is then buffered in a DEPTH-entry FIFO
//   that feeds the PCIe write module through an enable/ready handshake.
//
// Ports
//   clk, rst_n   clock; synchronous active-low reset
//   src_valid    per-source request valid
//   src_data     per-source packet, source i at [i*128 +: 128]
//   src_ack      one-hot combinational grant; a transfer is valid & ack
//   wr_data      head packet, driven from storage; zero when the FIFO is empty
//   wr_enable    head valid (FIFO non-empty)
//   wr_ready     write module ready; the head pops when enable & ready
//   fifo_count   number of entries held
//   fifo_full    fifo_count == DEPTH
module pcie_wr_req_queue #(
  parameter int unsigned NSRC      = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SRCID_LSB = 102,
  parameter int unsigned SRCID_W   = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC-1:0]          src_valid,
  input  logic [NSRC*128-1:0]      src_data,
  output logic [NSRC-1:0]          src_ack,
  output logic [127:0]             wr_data,
  output logic                     wr_enable,
  input  logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  grant_idx, hi_idx, lo_idx;
  logic           grant_valid, hi_found, lo_found;
  logic [PW-1:0]  rd_q, wr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [127:0]   mem_q [DEPTH];
  logic [127:0]   push_pkt;
  logic           push, pop;

  // Round-robin: the lowest valid index >= rr_q wins; failing that, the lowest
  // valid index overall (the wrap-around case). Scanning downwards leaves the
  // lowest match in each set.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        if (i >= int'(rr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
        lo_found = 1'b1;
        lo_idx   = IW'(i);
      end
    end
    // A full FIFO blocks the grant even if a pop happens this cycle.
    grant_valid = !fifo_full && (hi_found || lo_found);
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    src_ack = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ack[i] = grant_valid && (grant_idx == IW'(i));
    end
  end

  // Packet transform: bit 127 belongs to the write module's toggle logic.
  always_comb begin
    push_pkt = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_idx == IW'(i)) begin
        push_pkt = src_data[i*128 +: 128];
      end
    end
    push_pkt[127]                     = 1'b0;
    push_pkt[SRCID_LSB +: SRCID_W]    = SRCID_W'(grant_idx);
  end

  assign push = grant_valid;
  assign pop  = wr_enable && wr_ready;

  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = (grant_idx == IW'(NSRC - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // Storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_pkt;
  end

  assign wr_enable  = (count_q != '0);
  assign wr_data    = wr_enable ? mem_q[rd_q] : '0;
  assign fifo_count = count_q;
  assign fifo_full  = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_pcie_wr_req_queue.sv
module tb_pcie_wr_req_queue;

  localparam int NSRC  = 4;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC*128-1:0]  src_data;
  logic [NSRC-1:0]      src_ack;
  logic [127:0]         wr_data;
  logic                 wr_enable;
  logic                 wr_ready;
  logic [3:0]           fifo_count;
  logic                 fifo_full;

  pcie_wr_req_queue #(
    .NSRC     (NSRC),
    .DEPTH    (DEPTH),
    .SRCID_LSB(102),
    .SRCID_W  (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ack   (src_ack),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .wr_ready  (wr_ready),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] xform(input logic [127:0] d, input int idx);
    logic [127:0] r;
    logic [31:0]  id;
    id        = idx;
    r         = d;
    r[127]    = 1'b0;
    r[108:102] = id[6:0];
    return r;
  endfunction

  // Scoreboard / reference model.
  logic [127:0]    exp_q[$];
  int              count_m = 0;
  int              rr_m    = 0;
  int              gidx;
  int              cand;
  logic [NSRC-1:0] exp_ack;
  logic [NSRC-1:0] xfer = '0;
  logic [NSRC-1:0] auto_mask = '0;
  bit              mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        exp_q.delete();
        count_m = 0;
        rr_m    = 0;
        xfer    = '0;
      end else begin
        gidx    = -1;
        exp_ack = '0;
        if (count_m < DEPTH) begin
          for (int k = 0; k < NSRC; k++) begin
            cand = (rr_m + k) % NSRC;
            if (gidx < 0 && src_valid[cand]) gidx = cand;
          end
        end
        if (gidx >= 0) exp_ack[gidx] = 1'b1;
        check_eq("src_ack", 128'(src_ack), 128'(exp_ack));
        check_eq("fifo_count", 128'(fifo_count), 128'(count_m));
        check_eq("fifo_full", 128'(fifo_full), 128'(count_m == DEPTH));
        check_eq("wr_enable", 128'(wr_enable), 128'(count_m != 0));
        if (count_m > 0) check_eq("head_data", wr_data, exp_q[0]);
        else             check_eq("empty_data", wr_data, 128'd0);
        xfer = src_ack & src_valid;
        if (count_m > 0 && wr_ready) begin
          void'(exp_q.pop_front());
          count_m--;
        end
        if (gidx >= 0) begin
          exp_q.push_back(xform(src_data[gidx*128 +: 128], gidx));
          rr_m = (gidx + 1) % NSRC;
          count_m++;
        end
      end
    end
  end

  // Advance one clock; sources that transferred either drop valid or offer a
  // fresh packet.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NSRC; i++) begin
      if (xfer[i]) begin
        if (auto_mask[i]) src_data[i*128 +: 128] = rnd_pkt();
        else              src_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    auto_mask = '0;
    wr_ready  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_all();
    for (int i = 0; i < NSRC; i++) src_data[i*128 +: 128] = rnd_pkt();
    src_valid = '1;
    auto_mask = '1;
  endtask

  initial begin
    logic [127:0] d;
    rst_n     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    wr_ready  = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Reset state
    @(negedge clk);
    check_eq("rst_count", 128'(fifo_count), 128'd0);
    check_eq("rst_enable", 128'(wr_enable), 128'd0);
    check_eq("rst_data", wr_data, 128'd0);
    check_eq("rst_ack", 128'(src_ack), 128'd0);

    // Single all-ones packet from src0, popped immediately
    src_data[127:0] = '1;
    src_valid       = 4'b0001;
    wr_ready        = 1'b1;
    @(negedge clk);
    check_eq("t1_ack", 128'(src_ack), 128'h1);
    tick();
    @(negedge clk);
    check_eq("t1_enable", 128'(wr_enable), 128'd1);
    check_eq("t1_data", wr_data, {1'b0, {18{1'b1}}, 7'd0, {102{1'b1}}});
    tick();

    // All sources valid, no drain: rotating grants until full
    do_reset();
    fill_all();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("t2_order", 128'(src_ack), 128'(1 << (k % 4)));
      tick();
    end
    @(negedge clk);
    check_eq("t2_count", 128'(fifo_count), 128'd8);
    check_eq("t2_full", 128'(fifo_full), 128'd1);
    check_eq("t2_noack", 128'(src_ack), 128'd0);
    tick();
    tick();

    // Full FIFO drained by single-cycle ready pulses
    for (int p = 0; p < 5; p++) begin
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      @(negedge clk);
      check_eq("t3_count7", 128'(fifo_count), 128'd7);
      check_eq("t3_regrant", 128'(src_ack != 0), 128'd1);
      tick();
      tick();
      tick();
    end

    // Reset with 5 entries buffered
    do_reset();
    fill_all();
    repeat (5) tick();
    @(negedge clk);
    check_eq("t5_pre_count", 128'(fifo_count), 128'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_count", 128'(fifo_count), 128'd0);
    check_eq("t5_enable", 128'(wr_enable), 128'd0);
    check_eq("t5_first_grant", 128'(src_ack), 128'h1);
    tick();

    // Source-ID stamping from src2
    do_reset();
    d           = rnd_pkt();
    d[108:102]  = 7'h55;
    src_data[2*128 +: 128] = d;
    src_valid   = 4'b0100;
    wr_ready    = 1'b1;
    @(negedge clk);
    check_eq("t4_ack", 128'(src_ack), 128'h4);
    tick();
    @(negedge clk);
    check_eq("t4_srcid", 128'(wr_data[108:102]), 128'h02);
    tick();

    // Simultaneous push and pop at count 3
    do_reset();
    fill_all();
    repeat (3) tick();
    src_valid = '0;
    auto_mask = '0;
    @(negedge clk);
    check_eq("t6_pre_count", 128'(fifo_count), 128'd3);
    src_data[1*128 +: 128] = rnd_pkt();
    src_valid = 4'b0010;
    wr_ready  = 1'b1;
    tick();
    wr_ready = 1'b0;
    @(negedge clk);
    check_eq("t6_count", 128'(fifo_count), 128'd3);

    // Drain everything (bounded)
    wr_ready  = 1'b1;
    src_valid = '0;
    for (int c = 0; c < 20 && fifo_count != 0; c++) tick();
    @(negedge clk);
    check_eq("drain_count", 128'(fifo_count), 128'd0);
    check_eq("drain_sb", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
